dmem_access_unit: RTL and testbench

- MEM-stage load/store unit. Consumes the decoded memory controls (mem_read, mem_write, d_size, d_unsigned) produced by the main control unit, plus the ALU-computed address and rs2 store data.
- Drives a req/gnt/rvalid data-memory bus. Generates byte enables and store-data lane replication, aligns and sign/zero-extends load data, and stalls the pipeline until the access completes.
- Detects misaligned accesses and bus timeouts.

---
 rtl/dmem_access_unit_if.sv | 23 ++
 rtl/dmem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_dmem_access_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Data-memory req/gnt/rvalid bus between the load/store unit (master) and memory (slave).
interface dmem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  o_dmem_req;
    logic                  o_dmem_we;
    logic [ADDR_WIDTH-1:0] o_dmem_addr;
    logic [3:0]            o_dmem_be;
    logic [31:0]           o_dmem_wdata;
    logic                  i_dmem_gnt;
    logic                  i_dmem_rvalid;
    logic [31:0]           i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: byte enables, lane replication, load alignment/extension,
// pipeline stall, misalignment detection and bus timeout.
//
// state  | meaning
// IDLE   | no access in flight; accepts an aligned access
// REQ    | request on the bus, waiting for gnt
// WAIT_R | load granted, waiting for rvalid
// DONE   | one-cycle completion, pipeline advances, inputs ignored
module dmem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_d_size,
    input  logic                  i_d_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    dmem_access_unit_if.master    dmem,
    output logic                  o_stall,
    output logic [31:0]           o_rdata,
    output logic                  o_done,
    output logic                  o_misaligned,
    output logic                  o_bus_error
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic                  err_q;
    logic [31:0]           rdata_q;

    logic        access, misaligned, accept, cnt_hit;
    logic [1:0]  off;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign access     = i_valid & (i_mem_read | i_mem_write);
    assign off        = i_addr[1:0];
    assign misaligned = ((i_d_size == 2'b01) & off[0]) | (i_d_size[1] & (off != 2'b00));
    // Reset gating keeps o_stall low while reset is held with an access still presented.
    assign accept     = (state_q == S_IDLE) & access & ~misaligned & ~i_reset;
    assign cnt_hit    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_wdata;
        case (i_d_size)
            2'b00: begin
                be_new    = 4'b0001 << off;
                wdata_new = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << off;
                wdata_new = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = dmem.i_dmem_rdata[7:0];
            2'd1:    byte_sel = dmem.i_dmem_rdata[15:8];
            2'd2:    byte_sel = dmem.i_dmem_rdata[23:16];
            default: byte_sel = dmem.i_dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem.i_dmem_rdata[31:16] : dmem.i_dmem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = dmem.i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_REQ;
            S_REQ: begin
                if (dmem.i_dmem_gnt) state_d = we_q ? S_DONE : S_WAIT_R;
                else if (cnt_hit)    state_d = S_DONE;
            end
            S_WAIT_R: if (dmem.i_dmem_rvalid | cnt_hit) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if ((state_q == S_REQ) || (state_q == S_WAIT_R))
            cnt_d = cnt_q + CW'(1);
    end

    always_comb begin
        dmem.o_dmem_req   = (state_q == S_REQ);
        dmem.o_dmem_we    = we_q;
        dmem.o_dmem_addr  = addr_q;
        dmem.o_dmem_be    = be_q;
        dmem.o_dmem_wdata = wdata_q;
        o_stall           = accept | (state_q == S_REQ) | (state_q == S_WAIT_R);
        o_done            = (state_q == S_DONE);
        o_bus_error       = (state_q == S_DONE) & err_q;
        o_misaligned      = access & misaligned;
        o_rdata           = rdata_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                S_IDLE: if (accept) begin
                    addr_q  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                    be_q    <= be_new;
                    wdata_q <= wdata_new;
                    we_q    <= i_mem_write;
                    size_q  <= i_d_size;
                    uns_q   <= i_d_unsigned;
                    off_q   <= off;
                    err_q   <= 1'b0;
                end
                S_REQ: if (!dmem.i_dmem_gnt && cnt_hit) err_q <= 1'b1;
                S_WAIT_R: begin
                    if (dmem.i_dmem_rvalid) rdata_q <= load_ext;
                    else if (cnt_hit)       err_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit with a 4-cycle bus timeout.
module tb_dmem_access_unit;
    localparam int AW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, mrd, mwr, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic        stall, done, mis, berr;
    logic [31:0] rd_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered by run_access
    int          r_stall, r_req, r_done;
    logic        r_err, r_post, r_ok, r_we;
    logic [31:0] r_addr, r_wd;
    logic [3:0]  r_be;

    dmem_access_unit_if #(.ADDR_WIDTH(AW)) bus();

    dmem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_mem_read(mrd), .i_mem_write(mwr),
        .i_d_size(sz), .i_d_unsigned(uns), .i_addr(addr), .i_wdata(wdata), .dmem(bus),
        .o_stall(stall), .o_rdata(rd_o), .o_done(done), .o_misaligned(mis), .o_bus_error(berr)
    );

    always #5 clk = ~clk;

    // Drives one access and plays the memory side: gnt on REQ cycle gnt_at, rvalid on
    // WAIT_R cycle rv_at (0 = never). Records what the DUT showed; checks live in the tests.
    task automatic run_access(input logic wr, input logic [1:0] s, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gnt_at, input int rv_at, input logic [31:0] mem_rd);
        int  wait_cyc;
        bit  granted, completed;
        wait_cyc = 0; granted = 0; completed = 0;
        r_stall = 0; r_req = 0; r_done = 0; r_err = 0; r_post = 0; r_ok = 0;
        r_addr = '0; r_be = '0; r_wd = '0; r_we = 0;
        @(posedge clk); #1;
        valid = 1; mwr = wr; mrd = ~wr; sz = s; uns = u; addr = a; wdata = wd;
        for (int c = 0; c < 40; c++) begin
            #1;
            bus.i_dmem_gnt = 0; bus.i_dmem_rvalid = 0;
            if (stall) r_stall++;
            if (bus.o_dmem_req) begin
                r_req++;
                if (r_req == 1) begin
                    r_addr = bus.o_dmem_addr; r_be = bus.o_dmem_be;
                    r_wd = bus.o_dmem_wdata; r_we = bus.o_dmem_we;
                end
                if (r_req == gnt_at) begin bus.i_dmem_gnt = 1; granted = 1; end
            end else if (granted && stall) begin
                wait_cyc++;
                if (wait_cyc == rv_at) begin bus.i_dmem_rvalid = 1; bus.i_dmem_rdata = mem_rd; end
            end
            if (done) begin r_done++; r_err = r_err | berr; completed = 1; end
            @(posedge clk); #1;
            if (completed) begin
                valid = 0; mrd = 0; mwr = 0;
                #1;
                r_post = done | bus.o_dmem_req | stall;
                r_ok = 1;
                break;
            end
        end
        valid = 0; mrd = 0; mwr = 0; bus.i_dmem_gnt = 0; bus.i_dmem_rvalid = 0;
    endtask

    task automatic test_reset;
        rst = 1; valid = 0; mrd = 0; mwr = 0; uns = 0; sz = 0; addr = 0; wdata = 0;
        bus.i_dmem_gnt = 0; bus.i_dmem_rvalid = 0; bus.i_dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_dmem_req, bus.o_dmem_we, done, berr, stall} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req/we/done/err/stall=%b want 00000",
                     {bus.o_dmem_req, bus.o_dmem_we, done, berr, stall});
        end
        n_checks++;
        if ({bus.o_dmem_addr, bus.o_dmem_be, bus.o_dmem_wdata, rd_o} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h be=%b wdata=%h rdata=%h want all zero",
                     bus.o_dmem_addr, bus.o_dmem_be, bus.o_dmem_wdata, rd_o);
        end
        rst = 0;
    endtask

    task automatic test_store_byte;
        run_access(1, 2'b00, 0, 32'h0000_1003, 32'h0000_00AB, 2, 0, 32'h0);
        n_checks++;
        if (r_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr: got %h want 00001000", r_addr); end
        n_checks++;
        if (r_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", r_be); end
        n_checks++;
        if (r_wd !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want abababab", r_wd); end
        n_checks++;
        if (r_we !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b want 1", r_we); end
        n_checks++;
        if (r_stall != 3) begin n_fail++; $display("FAIL sb_stall_cycles: got %0d want 3", r_stall); end
        n_checks++;
        if (!r_ok || r_done != 1 || r_err !== 1'b0 || r_post !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_done: ok=%b done_cycles=%0d err=%b post=%b want 1/1/0/0", r_ok, r_done, r_err, r_post);
        end
    endtask

    task automatic test_load_half;
        run_access(0, 2'b01, 0, 32'h0000_2002, 32'h0, 1, 1, 32'h8001_1234);
        n_checks++;
        if (r_be !== 4'b1100 || r_addr !== 32'h0000_2000 || r_we !== 1'b0) begin
            n_fail++; $display("FAIL lh_bus: be=%b addr=%h we=%b want 1100/00002000/0", r_be, r_addr, r_we);
        end
        n_checks++;
        if (rd_o !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_signed: got %h want ffff8001", rd_o); end
        n_checks++;
        if (r_stall != 3 || r_done != 1 || r_post !== 1'b0) begin
            n_fail++; $display("FAIL lh_timing: stall=%0d done=%0d post=%b want 3/1/0", r_stall, r_done, r_post);
        end
        run_access(0, 2'b01, 1, 32'h0000_2002, 32'h0, 1, 1, 32'h8001_1234);
        n_checks++;
        if (rd_o !== 32'h0000_8001) begin n_fail++; $display("FAIL lh_unsigned: got %h want 00008001", rd_o); end
        run_access(0, 2'b01, 1, 32'h0000_2000, 32'h0, 1, 1, 32'h8001_1234);
        n_checks++;
        if (rd_o !== 32'h0000_1234) begin n_fail++; $display("FAIL lh_low_half: got %h want 00001234", rd_o); end
    endtask

    task automatic test_load_byte;
        run_access(0, 2'b00, 0, 32'h0000_5001, 32'h0, 1, 1, 32'h0000_F000);
        n_checks++;
        if (r_be !== 4'b0010) begin n_fail++; $display("FAIL lb_be: got %b want 0010", r_be); end
        n_checks++;
        if (rd_o !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL lb_signed: got %h want fffffff0", rd_o); end
        run_access(0, 2'b00, 1, 32'h0000_5001, 32'h0, 1, 1, 32'h0000_F000);
        n_checks++;
        if (rd_o !== 32'h0000_00F0) begin n_fail++; $display("FAIL lb_unsigned: got %h want 000000f0", rd_o); end
        run_access(0, 2'b00, 0, 32'h0000_5003, 32'h0, 1, 1, 32'h8001_1234);
        n_checks++;
        if (rd_o !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_top_lane: got %h want ffffff80", rd_o); end
        run_access(0, 2'b10, 0, 32'h0000_5004, 32'h0, 1, 1, 32'h1234_5678);
        n_checks++;
        if (rd_o !== 32'h1234_5678 || r_be !== 4'b1111) begin
            n_fail++; $display("FAIL lw: rdata=%h be=%b want 12345678/1111", rd_o, r_be);
        end
    endtask

    task automatic test_store_variants;
        run_access(1, 2'b01, 0, 32'h0000_6002, 32'h1234_ABCD, 1, 0, 32'h0);
        n_checks++;
        if (r_be !== 4'b1100 || r_wd !== 32'hABCD_ABCD) begin
            n_fail++; $display("FAIL sh: be=%b wdata=%h want 1100/abcdabcd", r_be, r_wd);
        end
        run_access(1, 2'b11, 0, 32'h0000_7000, 32'hDEAD_BEEF, 1, 0, 32'h0);
        n_checks++;
        if (r_be !== 4'b1111 || r_wd !== 32'hDEAD_BEEF || r_stall != 2) begin
            n_fail++; $display("FAIL sw_size3: be=%b wdata=%h stall=%0d want 1111/deadbeef/2", r_be, r_wd, r_stall);
        end
        n_checks++;
        if (rd_o !== 32'h1234_5678) begin n_fail++; $display("FAIL store_keeps_rdata: got %h want 12345678", rd_o); end
    endtask

    task automatic test_misaligned;
        logic saw_req, saw_stall;
        @(posedge clk); #1;
        valid = 1; mrd = 1; mwr = 0; sz = 2'b10; uns = 0; addr = 32'h0000_3001;
        saw_req = 0; saw_stall = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_word_flag: got %b want 1", mis); end
            saw_req = saw_req | bus.o_dmem_req; saw_stall = saw_stall | stall;
            @(posedge clk); #1;
        end
        sz = 2'b01; addr = 32'h0000_3003; mrd = 0; mwr = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_half_flag: got %b want 1", mis); end
            saw_req = saw_req | bus.o_dmem_req; saw_stall = saw_stall | stall;
            @(posedge clk); #1;
        end
        n_checks++;
        if (saw_req !== 1'b0 || saw_stall !== 1'b0) begin
            n_fail++; $display("FAIL mis_no_access: req=%b stall=%b want 0/0", saw_req, saw_stall);
        end
        addr = 32'h0000_3002;
        #1;
        n_checks++;
        if (mis !== 1'b0 || stall !== 1'b1) begin
            n_fail++; $display("FAIL aligned_half: mis=%b stall=%b want 0/1", mis, stall);
        end
        valid = 0; mwr = 0;
    endtask

    task automatic test_timeout;
        run_access(0, 2'b10, 0, 32'h0000_8000, 32'h0, 0, 0, 32'h0);
        n_checks++;
        if (r_req != 4 || r_stall != 5) begin
            n_fail++; $display("FAIL to_req_cycles: req=%0d stall=%0d want 4/5", r_req, r_stall);
        end
        n_checks++;
        if (!r_ok || r_done != 1 || r_err !== 1'b1 || r_post !== 1'b0) begin
            n_fail++; $display("FAIL to_error: ok=%b done=%0d err=%b post=%b want 1/1/1/0", r_ok, r_done, r_err, r_post);
        end
        n_checks++;
        if (rd_o !== 32'h1234_5678) begin n_fail++; $display("FAIL to_rdata_kept: got %h want 12345678", rd_o); end
        run_access(1, 2'b10, 0, 32'h0000_8004, 32'h5555_AAAA, 4, 0, 32'h0);
        n_checks++;
        if (!r_ok || r_err !== 1'b0 || r_done != 1 || r_req != 4) begin
            n_fail++; $display("FAIL to_gnt_edge: ok=%b err=%b done=%0d req=%0d want 1/0/1/4", r_ok, r_err, r_done, r_req);
        end
        run_access(0, 2'b10, 0, 32'h0000_8008, 32'h0, 1, 0, 32'h0);
        n_checks++;
        if (!r_ok || r_err !== 1'b1 || r_stall != 6 || rd_o !== 32'h1234_5678) begin
            n_fail++; $display("FAIL to_wait_r: ok=%b err=%b stall=%0d rdata=%h want 1/1/6/12345678", r_ok, r_err, r_stall, rd_o);
        end
        run_access(0, 2'b10, 0, 32'h0000_800C, 32'h0, 3, 4, 32'hA5A5_0F0F);
        n_checks++;
        if (!r_ok || r_err !== 1'b0 || r_stall != 8 || rd_o !== 32'hA5A5_0F0F) begin
            n_fail++; $display("FAIL to_rvalid_edge: ok=%b err=%b stall=%0d rdata=%h want 1/0/8/a5a50f0f", r_ok, r_err, r_stall, rd_o);
        end
    endtask

    task automatic test_reset_mid_access;
        @(posedge clk); #1;
        valid = 1; mrd = 1; mwr = 0; sz = 2'b10; uns = 0; addr = 32'h0000_4000;
        @(posedge clk); #1;
        rst = 1;
        #1;
        n_checks++;
        if (bus.o_dmem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_in_req: req=%b stall=%b want 0/0", bus.o_dmem_req, stall);
        end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        bus.i_dmem_gnt = 1;
        @(posedge clk); #1;
        bus.i_dmem_gnt = 0;
        rst = 1;
        #1;
        n_checks++;
        if (bus.o_dmem_req !== 1'b0 || stall !== 1'b0 || rd_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_in_wait_r: req=%b stall=%b rdata=%h want 0/0/0", bus.o_dmem_req, stall, rd_o);
        end
        @(posedge clk); #1;
        rst = 0; valid = 0; mrd = 0;
        @(posedge clk); #1;
        bus.i_dmem_rvalid = 1; bus.i_dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.i_dmem_rvalid = 0;
        #1;
        n_checks++;
        if (rd_o !== 32'h0 || done !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL late_rvalid: rdata=%h done=%b stall=%b want 0/0/0", rd_o, done, stall);
        end
        run_access(0, 2'b10, 0, 32'h0000_4000, 32'h0, 1, 1, 32'h0BAD_C0DE);
        n_checks++;
        if (!r_ok || rd_o !== 32'h0BAD_C0DE || r_err !== 1'b0 || r_stall != 3) begin
            n_fail++; $display("FAIL post_reset_load: ok=%b rdata=%h err=%b stall=%0d want 1/0badc0de/0/3", r_ok, rd_o, r_err, r_stall);
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_load_byte();
        test_store_variants();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
